pr_rtn_arb: RTL and testbench



---
 rtl/al_pkg.sv | 12 +
 rtl/pr_compact4.sv | 30 +++
 rtl/pr_rtn_arb.sv | 103 ++++++++++
 tb/tb_pr_rtn_arb.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/al_pkg.sv
// Shared allocation-stage constants and types used by the freed-register return path.
package al_pkg;

  localparam int PR_W      = 6;
  localparam int NUM_PR    = 64;
  localparam int RTN_DEPTH = 16;
  localparam int RTN_SRC   = 4;
  localparam int RTN_DRAIN = 2;

  typedef logic [PR_W-1:0] pr_t;

endpackage

// File: rtl/pr_compact4.sv
// Packs the valid return slots into consecutive entries in ascending slot order.
// Returns the number of valid slots.
module pr_compact4 #(
  parameter int PR_W    = 6,
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         vld_in,
  input  logic [NUM_SRC*PR_W-1:0]    pr_in,
  output logic [NUM_SRC*PR_W-1:0]    ent_out,
  output logic [$clog2(NUM_SRC+1)-1:0] cnt_out
);

  localparam int CNT_W = $clog2(NUM_SRC+1);

  logic [CNT_W-1:0] cnt;

  // Each valid slot lands at the position given by the number of valid slots below it.
  always_comb begin
    ent_out = '0;
    cnt     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vld_in[i]) begin
        ent_out[int'(cnt)*PR_W +: PR_W] = pr_in[i*PR_W +: PR_W];
        cnt = cnt + 1'b1;
      end
    end
    cnt_out = cnt;
  end

endmodule

// File: rtl/pr_rtn_arb.sv
// Return arbiter for freed physical registers. It compacts up to NUM_SRC returns per cycle into a
// circular buffer and drains up to DRAIN entries per cycle to the free list.
module pr_rtn_arb #(
  parameter int PR_W    = al_pkg::PR_W,
  parameter int NUM_SRC = al_pkg::RTN_SRC,
  parameter int DEPTH   = al_pkg::RTN_DEPTH,
  parameter int DRAIN   = al_pkg::RTN_DRAIN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         rtn_vld_in,
  input  logic [NUM_SRC*PR_W-1:0]    rtn_pr_in,
  input  logic                       fl_rdy_in,
  output logic [DRAIN-1:0]           fl_vld_out,
  output logic [DRAIN*PR_W-1:0]      fl_pr_out,
  output logic                       stall_to_SCH,
  output logic [$clog2(DEPTH):0]     occ_out,
  output logic                       ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int IN_W  = $clog2(NUM_SRC+1);
  localparam int DR_W  = $clog2(DRAIN+1);

  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        occ;
  logic [CNT_W-1:0]        occ_nxt;
  logic [PR_W-1:0]         mem [DEPTH];

  logic [NUM_SRC*PR_W-1:0] ent;
  logic [IN_W-1:0]         nin;
  logic [DR_W-1:0]         nout;
  logic [SUM_W-1:0]        room;
  logic [SUM_W-1:0]        nwr;
  logic                    drop;

  pr_compact4 #(
    .PR_W    (PR_W),
    .NUM_SRC (NUM_SRC)
  ) u_compact (
    .vld_in  (rtn_vld_in),
    .pr_in   (rtn_pr_in),
    .ent_out (ent),
    .cnt_out (nin)
  );

  // Drain lanes depend only on registered state, so same-cycle enqueues are never visible here.
  always_comb begin
    fl_vld_out = '0;
    fl_pr_out  = '0;
    for (int j = 0; j < DRAIN; j++) begin
      fl_vld_out[j]                = (occ > CNT_W'(j));
      fl_pr_out[j*PR_W +: PR_W]    = mem[head + PTR_W'(j)];
    end
  end

  always_comb begin
    nout = '0;
    if (fl_rdy_in) begin
      for (int j = 0; j < DRAIN; j++) begin
        if (fl_vld_out[j]) nout = nout + 1'b1;
      end
    end
  end

  // Slots freed by this cycle's drain may be reused by this cycle's enqueue.
  always_comb begin
    room    = SUM_W'(DEPTH) - SUM_W'(occ) + SUM_W'(nout);
    drop    = (SUM_W'(nin) > room);
    nwr     = drop ? room : SUM_W'(nin);
    occ_nxt = CNT_W'(SUM_W'(occ) + nwr - SUM_W'(nout));
  end

  assign stall_to_SCH = (occ > CNT_W'(DEPTH - NUM_SRC));
  assign occ_out      = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      ovf_err <= 1'b0;
    end else begin
      head <= head + PTR_W'(nout);
      tail <= tail + PTR_W'(nwr);
      occ  <= occ_nxt;
      if (drop) ovf_err <= 1'b1;
    end
  end

  // Storage is intentionally left uncleared by reset; only accepted entries are written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (SUM_W'(j) < nwr) mem[tail + PTR_W'(j)] <= ent[j*PR_W +: PR_W];
      end
    end
  end

endmodule

// File: tb/tb_pr_rtn_arb.sv
// Scoreboard bench for pr_rtn_arb. A queue model of the buffer predicts lanes, occupancy,
// stall and the sticky overflow flag.
module tb_pr_rtn_arb;
  import al_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rtn_vld_in = '0;
  logic [23:0] rtn_pr_in = '0;
  logic        fl_rdy_in = 1'b0;
  logic [1:0]  fl_vld_out;
  logic [11:0] fl_pr_out;
  logic        stall_to_SCH;
  logic [4:0]  occ_out;
  logic        ovf_err;

  pr_t expQ[$];
  bit  expOvf = 1'b0;
  int  numChecks = 0;
  int  numErrors = 0;

  pr_rtn_arb dut (
    .clk          (clk),
    .rst          (rst),
    .rtn_vld_in   (rtn_vld_in),
    .rtn_pr_in    (rtn_pr_in),
    .fl_rdy_in    (fl_rdy_in),
    .fl_vld_out   (fl_vld_out),
    .fl_pr_out    (fl_pr_out),
    .stall_to_SCH (stall_to_SCH),
    .occ_out      (occ_out),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Compare DUT state-derived outputs against the model, then advance the model by one cycle.
  task automatic applyStimulus(input logic [3:0] vld, input logic [23:0] prs, input logic rdy);
    int sz;
    int nout;
    int room;
    @(negedge clk);
    rtn_vld_in = vld;
    rtn_pr_in  = prs;
    fl_rdy_in  = rdy;
    #1;
    sz = expQ.size();
    checkOutput("fl_vld", int'(fl_vld_out), (sz >= 2) ? 3 : (sz >= 1) ? 1 : 0);
    if (sz >= 1) checkOutput("lane0", int'(fl_pr_out[5:0]), int'(expQ[0]));
    if (sz >= 2) checkOutput("lane1", int'(fl_pr_out[11:6]), int'(expQ[1]));
    checkOutput("occ", int'(occ_out), sz);
    checkOutput("stall", int'(stall_to_SCH), (sz > 12) ? 1 : 0);
    checkOutput("ovf", int'(ovf_err), int'(expOvf));
    nout = rdy ? ((sz >= 2) ? 2 : sz) : 0;
    for (int k = 0; k < nout; k++) void'(expQ.pop_front());
    room = 16 - expQ.size();
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) begin
        if (room > 0) begin
          expQ.push_back(pr_t'(prs[i*6 +: 6]));
          room--;
        end else begin
          expOvf = 1'b1;
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst        = 1'b1;
    rtn_vld_in = '0;
    fl_rdy_in  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    expOvf = 1'b0;
    #1;
    checkOutput("rst_vld", int'(fl_vld_out), 0);
    checkOutput("rst_stall", int'(stall_to_SCH), 0);
    checkOutput("rst_occ", int'(occ_out), 0);
    checkOutput("rst_ovf", int'(ovf_err), 0);
  endtask

  function automatic logic [23:0] packPr(input int s0, input int s1, input int s2, input int s3);
    return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  task automatic drainAll();
    for (int c = 0; c < 12; c++) applyStimulus(4'b0000, '0, 1'b1);
  endtask

  initial begin
    logic [3:0] rv;
    // Slots 1 and 3 return 7 and 9; lane 0 carries 7, lane 1 carries 9.
    doReset();
    applyStimulus(4'b1010, packPr(0, 7, 0, 9), 1'b1);
    applyStimulus(4'b0000, '0, 1'b1);
    checkOutput("t1_lanes", int'(fl_pr_out), int'({6'd9, 6'd7}));
    applyStimulus(4'b0000, '0, 1'b1);

    // Fill to 16 with the free list blocked.
    for (int c = 0; c < 4; c++) applyStimulus(4'b1111, packPr(4*c, 4*c+1, 4*c+2, 4*c+3), 1'b0);
    applyStimulus(4'b0000, '0, 1'b0);
    checkOutput("t2_full", int'(occ_out), 16);
    drainAll();

    // Overflow at occupancy 15: only the first of three returns is stored.
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus(4'b1111, packPr(c, c+10, c+20, c+30), 1'b0);
    applyStimulus(4'b0111, packPr(40, 41, 42, 0), 1'b0);
    applyStimulus(4'b0111, packPr(50, 51, 52, 0), 1'b0);
    applyStimulus(4'b0000, '0, 1'b0);
    checkOutput("t3_ovf", int'(ovf_err), 1);
    drainAll();

    // Pointer wrap: move head and tail to 14, then stream across index 15 to 0.
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus(4'b1111, packPr(1, 2, 3, 4), 1'b0);
    applyStimulus(4'b0011, packPr(5, 6, 0, 0), 1'b0);
    drainAll();
    applyStimulus(4'b1111, packPr(33, 34, 35, 36), 1'b1);
    applyStimulus(4'b1111, packPr(37, 38, 39, 40), 1'b1);
    applyStimulus(4'b0101, packPr(41, 0, 42, 0), 1'b1);
    drainAll();

    // Occupancy 1 while four returns arrive; only lane 0 is valid this cycle.
    doReset();
    applyStimulus(4'b0001, packPr(11, 0, 0, 0), 1'b0);
    applyStimulus(4'b1111, packPr(12, 13, 14, 15), 1'b1);
    applyStimulus(4'b0000, '0, 1'b0);
    checkOutput("t5_occ", int'(occ_out), 4);

    // Reset while nine entries are buffered.
    doReset();
    applyStimulus(4'b1111, packPr(1, 2, 3, 4), 1'b0);
    applyStimulus(4'b1111, packPr(5, 6, 7, 8), 1'b0);
    applyStimulus(4'b0001, packPr(9, 0, 0, 0), 1'b0);
    applyStimulus(4'b0000, '0, 1'b0);
    doReset();
    applyStimulus(4'b0000, '0, 1'b1);

    // Random traffic; producers mostly honour the stall.
    for (int c = 0; c < 300; c++) begin
      rv = 4'($urandom_range(0, 15));
      if (expQ.size() > 12 && $urandom_range(0, 3) != 0) rv = 4'b0000;
      applyStimulus(rv, 24'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
    $finish;
  end

endmodule
